// File: rtl/inst_fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage and its neighbours.
// Holds the fetch-to-decode bus layout, the branch bus width and the default reset PC.
package cpu_defs;

  // {fs_adef, fs_inst[31:0], fs_pc[31:0]}
  localparam int unsigned FS_TO_DS_BUS_WD = 65;
  // {br_taken, br_target[31:0]}
  localparam int unsigned BR_BUS_WD = 33;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  // Field offsets inside fs_to_ds_bus
  localparam int unsigned BUS_PC_LSB   = 0;
  localparam int unsigned BUS_PC_MSB   = 31;
  localparam int unsigned BUS_INST_LSB = 32;
  localparam int unsigned BUS_INST_MSB = 63;
  localparam int unsigned BUS_ADEF_BIT = 64;

  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  // Assemble the fetch-to-decode bus in its canonical field order.
  function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_to_ds(input logic        adef,
                                                               input logic [31:0] inst,
                                                               input logic [31:0] pc);
    return {adef, inst, pc};
  endfunction

  // Word fetches need a 4-byte aligned address.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Fetch stage external bus: instruction SRAM port, fetch-to-decode handshake and the
// branch redirect from decode. master = fetch stage side, slave = SRAM/decode side.
interface inst_fetch_stage_if;
  import cpu_defs::*;

  // Instruction SRAM
  logic                       inst_sram_en;
  logic                       inst_sram_we;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;

  // Fetch to decode
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       ds_allowin;

  // Redirect from decode
  logic                       br_taken;
  logic [31:0]                br_target;

  modport master (
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    input  ds_allowin,
    input  br_taken,
    input  br_target
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    output ds_allowin,
    output br_taken,
    output br_target
  );

endinterface

// File: rtl/inst_fetch_stage_buffer.sv
// fetch_inst_buffer: skid register for the instruction SRAM return.
// The SRAM word is only present the cycle after a request; if decode stalls that cycle the
// word is parked here and replayed until the handshake fires or a redirect cancels it.
module fetch_inst_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_valid,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic        ds_fire,
  input  logic [31:0] sram_rdata,
  output logic [31:0] inst
);

  logic        buf_valid;
  logic [31:0] inst_buf;
  logic        capture;
  logic        drop;

  // Capture only the first stalled cycle; later cycles carry no valid SRAM data.
  // capture and drop are mutually exclusive (capture needs ~ds_allowin and ~br_taken).
  assign capture = fs_valid & ~buf_valid & ~ds_allowin & ~br_taken;
  assign drop    = ds_fire | br_taken;

  // Skid register: clear on delivery or redirect, load on the first stall cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'h0;
    end else if (drop) begin
      buf_valid <= 1'b0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      inst_buf  <= sram_rdata;
    end
  end

  // Bypass the live SRAM word unless a parked one exists
  always_comb begin
    inst = buf_valid ? inst_buf : sram_rdata;
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage: owns the PC, issues reads to the 1-cycle instruction SRAM and hands
// {adef, inst, pc} to decode over a valid/allowin handshake. Branch redirects from decode
// cancel the instruction in IF and re-target the request issued in the same cycle.
// Optional build macro FS_ADEF_CHECK_EN: flag misaligned fetch addresses (fs_adef), suppress
// the SRAM read for them and deliver a zero instruction so decode can raise ADEF.
module inst_fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  inst_fetch_stage_if.master fs_bus
);

  // Pre-IF
  logic        to_fs_valid;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fetch_en;

  // IF
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fs_load;
  logic        ds_fire;
  logic        fs_adef;
  logic [31:0] buf_inst;
  logic [31:0] fs_inst;

  // ---------------------------------------------------------------------------------------
  // Pre-IF: next-PC selection and SRAM request
  // ---------------------------------------------------------------------------------------

  // Sequential PC wraps naturally at 32 bits; a redirect overrides it in the same cycle
  always_comb begin
    seq_pc = fs_pc + 32'd4;
    nextpc = fs_bus.br_taken ? fs_bus.br_target : seq_pc;
  end

  // Pre-IF goes valid on the first edge after reset so the first request is RESET_PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_fs_valid <= 1'b0;
    end else begin
      to_fs_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // IF: handshake and PC register
  // ---------------------------------------------------------------------------------------

  assign fs_ready_go = 1'b1;

  // A redirect always frees IF: the wrong-path instruction is dropped, not delivered
  assign fs_allowin = ~fs_valid | (fs_bus.ds_allowin & fs_ready_go) | fs_bus.br_taken;
  assign fs_load    = to_fs_valid & fs_allowin;
  assign ds_fire    = fs_bus.fs_to_ds_valid & fs_bus.ds_allowin;

  // PC/valid advance whenever a new fetch is accepted into IF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_pc    <= RESET_PC - 32'd4;
      fs_valid <= 1'b0;
    end else if (fs_load) begin
      fs_pc    <= nextpc;
      fs_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // SRAM return buffering
  // ---------------------------------------------------------------------------------------

  fetch_inst_buffer u_inst_buffer (
    .clk        (clk),
    .reset      (reset),
    .fs_valid   (fs_valid),
    .ds_allowin (fs_bus.ds_allowin),
    .br_taken   (fs_bus.br_taken),
    .ds_fire    (ds_fire),
    .sram_rdata (fs_bus.inst_sram_rdata),
    .inst       (buf_inst)
  );

  // ---------------------------------------------------------------------------------------
  // Address-error check (optional)
  // ---------------------------------------------------------------------------------------

`ifdef FS_ADEF_CHECK_EN
  logic nextpc_misaligned;

  assign nextpc_misaligned = pc_misaligned(nextpc);

  // adef tracks the PC it was computed for, so it loads together with fs_pc
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_adef <= 1'b0;
    end else if (fs_load) begin
      fs_adef <= nextpc_misaligned;
    end
  end

  // No SRAM read for a misaligned address; the slot still enters IF carrying adef
  assign fetch_en = fs_load & ~nextpc_misaligned;
  // The SRAM data is meaningless for a suppressed read, so deliver zero
  assign fs_inst  = fs_adef ? 32'h0 : buf_inst;
`else
  assign fs_adef  = 1'b0;
  assign fetch_en = fs_load;
  assign fs_inst  = buf_inst;
`endif

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------

  assign fs_bus.inst_sram_en    = fetch_en;
  assign fs_bus.inst_sram_we    = 1'b0;
  assign fs_bus.inst_sram_addr  = nextpc;
  assign fs_bus.inst_sram_wdata = 32'h0;

  assign fs_bus.fs_to_ds_valid  = fs_valid & fs_ready_go & ~fs_bus.br_taken;
  assign fs_bus.fs_to_ds_bus    = pack_fs_to_ds(fs_adef, fs_inst, fs_pc);

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Testbench for inst_fetch_stage. A reference model tracks which PC sits in IF and whether
// it is valid; delivered instructions are expected to equal the memory contents at that PC.
// The SRAM model returns random junk whenever it was not read, so lost or stale words show up.
module tb_inst_fetch_stage;
  import cpu_defs::*;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  inst_fetch_stage_if bus_if ();

  inst_fetch_stage #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .fs_bus (bus_if)
  );

  always #5 clk = ~clk;

  // Memory image: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h9e3779b9;
  endfunction

  // Synchronous SRAM, 1-cycle latency; junk when not enabled
  always @(posedge clk) begin
    if (bus_if.inst_sram_en) bus_if.inst_sram_rdata <= mem_word(bus_if.inst_sram_addr);
    else                     bus_if.inst_sram_rdata <= $urandom;
  end

  // Reference model state
  bit          m_started;
  bit          m_valid;
  bit          m_adef;
  logic [31:0] m_pc;

  // Expectations for the current cycle
  logic        exp_valid;
  logic        exp_en;
  logic [31:0] exp_addr;
  logic [64:0] exp_bus;

  task automatic model_reset();
    m_started = 1'b0;
    m_valid   = 1'b0;
    m_adef    = 1'b0;
    m_pc      = RST_PC - 32'd4;
  endtask

  task automatic compute_exp(input logic allow, input logic br, input logic [31:0] tgt);
    logic [31:0] nxt;
    nxt       = br ? tgt : m_pc + 32'd4;
    exp_valid = m_valid && !br;
    exp_en    = m_started && (!m_valid || allow || br);
    exp_addr  = nxt;
`ifdef FS_ADEF_CHECK_EN
    if (nxt[1:0] != 2'b00) exp_en = 1'b0;
    exp_bus = {m_adef, (m_adef ? 32'h0 : mem_word(m_pc)), m_pc};
`else
    exp_bus = {1'b0, mem_word(m_pc), m_pc};
`endif
  endtask

  // Advance one clock (model follows the inputs held through the edge), then apply new
  // inputs and sample point is posedge+4.
  task automatic drive(input logic allow, input logic br, input logic [31:0] tgt);
    logic        load;
    logic [31:0] nxt;
    nxt  = bus_if.br_taken ? bus_if.br_target : m_pc + 32'd4;
    load = m_started && (!m_valid || bus_if.ds_allowin || bus_if.br_taken);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (load) begin
        m_pc    = nxt;
        m_valid = 1'b1;
        m_adef  = (nxt[1:0] != 2'b00);
      end
      m_started = 1'b1;
    end
    #1;
    bus_if.ds_allowin = allow;
    bus_if.br_taken   = br;
    bus_if.br_target  = tgt;
    #3;
    compute_exp(allow, br, tgt);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      checks++;
      if (bus_if.inst_sram_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_en cyc=%0d got=%b exp=0", i, bus_if.inst_sram_en);
      end
      checks++;
      if (bus_if.fs_to_ds_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, bus_if.fs_to_ds_valid);
      end
      checks++;
      if ({bus_if.inst_sram_we, bus_if.inst_sram_wdata} !== 33'h0) begin
        failures++;
        $display("FAIL reset_we_wdata got=%b/%h exp=0/0", bus_if.inst_sram_we,
                 bus_if.inst_sram_wdata);
      end
    end
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.inst_sram_en !== 1'b1 || bus_if.inst_sram_addr !== RST_PC) begin
      failures++;
      $display("FAIL first_req got en=%b addr=%h exp en=1 addr=%h", bus_if.inst_sram_en,
               bus_if.inst_sram_addr, RST_PC);
    end
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_req_valid got=%b exp=0", bus_if.fs_to_ds_valid);
    end
  endtask

  // Fetch RST_PC, stall 3 cycles holding RST_PC+4, then resume.
  task automatic test_fetch_stall();
    logic [4:0] allow_pat;
    allow_pat = 5'b10001;
    for (int i = 0; i < 5; i++) begin
      drive(allow_pat[i], 1'b0, 32'h0);
      checks++;
      if (bus_if.fs_to_ds_valid !== exp_valid) begin
        failures++;
        $display("FAIL stall_valid cyc=%0d got=%b exp=%b", i, bus_if.fs_to_ds_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus_if.fs_to_ds_bus !== exp_bus) begin
          failures++;
          $display("FAIL stall_bus cyc=%0d got=%h exp=%h", i, bus_if.fs_to_ds_bus, exp_bus);
        end
      end
      checks++;
      if (bus_if.inst_sram_en !== exp_en) begin
        failures++;
        $display("FAIL stall_en cyc=%0d got=%b exp=%b", i, bus_if.inst_sram_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (bus_if.inst_sram_addr !== exp_addr) begin
          failures++;
          $display("FAIL stall_addr cyc=%0d got=%h exp=%h", i, bus_if.inst_sram_addr, exp_addr);
        end
      end
      if (i == 0) begin
        checks++;
        if (bus_if.fs_to_ds_bus[31:0] !== RST_PC || bus_if.inst_sram_addr !== RST_PC + 32'd4) begin
          failures++;
          $display("FAIL seq_pc0 got pc=%h addr=%h exp pc=%h addr=%h",
                   bus_if.fs_to_ds_bus[31:0], bus_if.inst_sram_addr, RST_PC, RST_PC + 32'd4);
        end
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (bus_if.inst_sram_en !== 1'b0 ||
            bus_if.fs_to_ds_bus !== {1'b0, mem_word(RST_PC + 32'd4), RST_PC + 32'd4}) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got en=%b bus=%h exp en=0 bus=%h", i,
                   bus_if.inst_sram_en, bus_if.fs_to_ds_bus,
                   {1'b0, mem_word(RST_PC + 32'd4), RST_PC + 32'd4});
        end
      end
      if (i == 4) begin
        checks++;
        if (bus_if.inst_sram_addr !== RST_PC + 32'd8) begin
          failures++;
          $display("FAIL stall_resume got=%h exp=%h", bus_if.inst_sram_addr, RST_PC + 32'd8);
        end
      end
    end
  endtask

  // Redirect with IF holding RST_PC+8, then back-to-back redirects ending at a wrapping PC.
  task automatic test_redirect();
    logic [7:0]  br_pat;
    logic [31:0] tgt_tab [8];
    br_pat  = 8'b01001101;
    tgt_tab = '{32'h1c000100, 32'h0, 32'hfffffff0, 32'hfffffffc, 32'h0, 32'h0,
                32'h1c000040, 32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, br_pat[i], tgt_tab[i]);
      checks++;
      if (bus_if.fs_to_ds_valid !== exp_valid) begin
        failures++;
        $display("FAIL br_valid cyc=%0d got=%b exp=%b", i, bus_if.fs_to_ds_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus_if.fs_to_ds_bus !== exp_bus) begin
          failures++;
          $display("FAIL br_bus cyc=%0d got=%h exp=%h", i, bus_if.fs_to_ds_bus, exp_bus);
        end
      end
      checks++;
      if (bus_if.inst_sram_en !== exp_en || (exp_en && bus_if.inst_sram_addr !== exp_addr)) begin
        failures++;
        $display("FAIL br_req cyc=%0d got en=%b addr=%h exp en=%b addr=%h", i,
                 bus_if.inst_sram_en, bus_if.inst_sram_addr, exp_en, exp_addr);
      end
      if (i == 0) begin
        checks++;
        if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.fs_to_ds_bus[31:0] !== RST_PC + 32'd8 ||
            bus_if.inst_sram_addr !== 32'h1c000100) begin
          failures++;
          $display("FAIL br_cancel got valid=%b pc=%h addr=%h exp valid=0 pc=%h addr=1c000100",
                   bus_if.fs_to_ds_valid, bus_if.fs_to_ds_bus[31:0], bus_if.inst_sram_addr,
                   RST_PC + 32'd8);
        end
      end
      if (i == 1) begin
        checks++;
        if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.fs_to_ds_bus[31:0] !== 32'h1c000100) begin
          failures++;
          $display("FAIL br_target_pc got valid=%b pc=%h exp valid=1 pc=1c000100",
                   bus_if.fs_to_ds_valid, bus_if.fs_to_ds_bus[31:0]);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus_if.fs_to_ds_bus[31:0] !== 32'hfffffffc || bus_if.inst_sram_addr !== 32'h0) begin
          failures++;
          $display("FAIL br_last_wins_wrap got pc=%h addr=%h exp pc=fffffffc addr=0",
                   bus_if.fs_to_ds_bus[31:0], bus_if.inst_sram_addr);
        end
      end
    end
  endtask

  // Redirect while decode stalls with a parked instruction.
  task automatic test_redirect_in_stall();
    logic [4:0] allow_pat;
    logic [4:0] br_pat;
    allow_pat = 5'b10000;
    br_pat    = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      drive(allow_pat[i], br_pat[i], 32'h1c000200);
      checks++;
      if (bus_if.fs_to_ds_valid !== exp_valid) begin
        failures++;
        $display("FAIL brstall_valid cyc=%0d got=%b exp=%b", i, bus_if.fs_to_ds_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus_if.fs_to_ds_bus !== exp_bus) begin
          failures++;
          $display("FAIL brstall_bus cyc=%0d got=%h exp=%h", i, bus_if.fs_to_ds_bus, exp_bus);
        end
      end
      checks++;
      if (bus_if.inst_sram_en !== exp_en || (exp_en && bus_if.inst_sram_addr !== exp_addr)) begin
        failures++;
        $display("FAIL brstall_req cyc=%0d got en=%b addr=%h exp en=%b addr=%h", i,
                 bus_if.inst_sram_en, bus_if.inst_sram_addr, exp_en, exp_addr);
      end
      if (i == 3) begin
        checks++;
        if (bus_if.fs_to_ds_bus !== {1'b0, mem_word(32'h1c000200), 32'h1c000200}) begin
          failures++;
          $display("FAIL brstall_drop got=%h exp=%h", bus_if.fs_to_ds_bus,
                   {1'b0, mem_word(32'h1c000200), 32'h1c000200});
        end
      end
    end
  endtask

  // Reset asserted mid-stream for 2 cycles; outputs must drop without waiting for a clock.
  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.inst_sram_en !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got valid=%b en=%b exp 0/0", bus_if.fs_to_ds_valid,
               bus_if.inst_sram_en);
    end
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      checks++;
      if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.inst_sram_en !== 1'b0) begin
        failures++;
        $display("FAIL in_reset cyc=%0d got valid=%b en=%b exp 0/0", i, bus_if.fs_to_ds_valid,
                 bus_if.inst_sram_en);
      end
    end
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.inst_sram_en !== 1'b1 || bus_if.inst_sram_addr !== RST_PC) begin
      failures++;
      $display("FAIL restart_req got en=%b addr=%h exp en=1 addr=%h", bus_if.inst_sram_en,
               bus_if.inst_sram_addr, RST_PC);
    end
    drive(1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.fs_to_ds_bus !== exp_bus) begin
      failures++;
      $display("FAIL restart_bus got valid=%b bus=%h exp valid=1 bus=%h",
               bus_if.fs_to_ds_valid, bus_if.fs_to_ds_bus, exp_bus);
    end
  endtask

  // Random stall/redirect traffic against the model.
  task automatic test_random();
    logic        allow;
    logic        br;
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      allow = ($urandom % 4) != 0;
      br    = ($urandom % 8) == 0;
      tgt   = RST_PC + (($urandom % 1024) << 2);
      drive(allow, br, tgt);
      checks++;
      if (bus_if.fs_to_ds_valid !== exp_valid) begin
        failures++;
        $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus_if.fs_to_ds_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus_if.fs_to_ds_bus !== exp_bus) begin
          failures++;
          $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", i, bus_if.fs_to_ds_bus, exp_bus);
        end
      end
      checks++;
      if (bus_if.inst_sram_en !== exp_en || (exp_en && bus_if.inst_sram_addr !== exp_addr)) begin
        failures++;
        $display("FAIL rnd_req cyc=%0d got en=%b addr=%h exp en=%b addr=%h", i,
                 bus_if.inst_sram_en, bus_if.inst_sram_addr, exp_en, exp_addr);
      end
    end
  endtask

`ifdef FS_ADEF_CHECK_EN
  // Misaligned redirect: no SRAM read, slot delivered with adef set and a zero instruction.
  task automatic test_adef();
    drive(1'b1, 1'b1, 32'h1c000102);
    checks++;
    if (bus_if.inst_sram_en !== 1'b0) begin
      failures++;
      $display("FAIL adef_en got=%b exp=0", bus_if.inst_sram_en);
    end
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b1 ||
        bus_if.fs_to_ds_bus !== {1'b1, 32'h0, 32'h1c000102}) begin
      failures++;
      $display("FAIL adef_bus got valid=%b bus=%h exp valid=1 bus=%h", bus_if.fs_to_ds_valid,
               bus_if.fs_to_ds_bus, {1'b1, 32'h0, 32'h1c000102});
    end
    drive(1'b0, 1'b1, RST_PC);
    drive(1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_bus !== exp_bus || bus_if.fs_to_ds_bus[64] !== 1'b0) begin
      failures++;
      $display("FAIL adef_recover got=%h exp=%h", bus_if.fs_to_ds_bus, exp_bus);
    end
  endtask
`endif

  initial begin
    reset                  = 1'b1;
    bus_if.ds_allowin      = 1'b1;
    bus_if.br_taken        = 1'b0;
    bus_if.br_target       = 32'h0;
    bus_if.inst_sram_rdata = 32'h0;
    model_reset();
    test_reset();
    test_fetch_stall();
    test_redirect();
    test_redirect_in_stall();
    test_reset_mid();
    test_random();
`ifdef FS_ADEF_CHECK_EN
    test_adef();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Fetch stage that feeds the decode/execute core.
- Owns the PC and issues requests to the synchronous instruction SRAM (1-cycle read latency).
- Delivers {pc, inst} pairs downstream over a valid/allowin handshake.
- Accepts branch redirects from decode, and buffers the SRAM return when downstream stalls so no fetched word is lost.

Parameters:
RESET_PC, 32'h1c000000, address of the first instruction fetched after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-high
ds_allowin  input  1  decode can accept an instruction this cycle
br_taken  input  1  redirect request from decode, valid for one cycle
br_target  input  32  redirect address, qualified by br_taken
inst_sram_en  output  1  instruction SRAM read enable
inst_sram_we  output  1  instruction SRAM write enable, tied 0
inst_sram_addr  output  32  instruction SRAM address
inst_sram_wdata  output  32  tied 0
inst_sram_rdata  input  32  SRAM data, valid the cycle after an accepted request
fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction
fs_to_ds_bus  output  FS_TO_DS_BUS_WD  {fs_adef, fs_inst[31:0], fs_pc[31:0]}

Behaviour:
- Reset is asynchronous, active-high. The rule "one clock; reset is asynchronous and active-high" is fixed for this block.
- While reset is asserted:
  - fs_pc = RESET_PC-4, to_fs_valid = 0, fs_valid = 0, buf_valid = 0.
  - inst_sram_en = 0, fs_to_ds_valid = 0.
- Pre-IF:
  - to_fs_valid becomes 1 on the first clock edge after reset deasserts.
  - seq_pc = fs_pc+4, with 32-bit wrap-around (0xfffffffc+4 = 0).
  - nextpc = br_taken ? br_target : seq_pc.
  - inst_sram_addr = nextpc.
  - inst_sram_en = to_fs_valid & fs_allowin.
- First request after reset is RESET_PC, one cycle after reset deasserts.
- IF handshake:
  - fs_ready_go = 1.
  - fs_allowin = ~fs_valid | (ds_allowin & fs_ready_go) | br_taken.
  - fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.
- On each edge where to_fs_valid & fs_allowin:
  - fs_pc <= nextpc and fs_valid <= 1.
  - Otherwise fs_pc and fs_valid hold.
- Instruction buffer:
  - inst_sram_rdata is only meaningful the cycle after a request.
  - If fs_valid & ~buf_valid & ~ds_allowin & ~br_taken, capture inst_buf <= inst_sram_rdata and set buf_valid <= 1.
  - fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
  - buf_valid clears when the handshake fires (fs_to_ds_valid & ds_allowin) or on br_taken.
- Branch redirect:
  - br_taken is accepted unconditionally.
  - The instruction currently in IF is on the wrong path and is cancelled in that same cycle: not delivered, buffer dropped.
  - The request issued that cycle is br_target.
- Back-to-back br_taken: each one cancels and re-targets; the last one wins.
- Stall: while ds_allowin = 0 and no br_taken, no new request is issued, and fs_to_ds_bus stays bit-stable for the whole stall.
- Throughput: one instruction per cycle when ds_allowin is held at 1.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight SRAM data is ignored.

Optional Feature:
Macro FS_ADEF_CHECK_EN.
- Defined:
  - fs_adef <= (nextpc[1:0] != 0) when fs_pc is loaded.
  - inst_sram_en is suppressed for a misaligned nextpc.
  - fs_inst is forced to 32'h0 when fs_adef = 1.
  - The instruction is still delivered with fs_adef = 1 so that downstream can raise ADEF.
- Undefined: fs_adef is tied 0, and no address check or suppression logic is built.

Decomposition:
- Shared package cpu_defs holds:
  - FS_TO_DS_BUS_WD = 65
  - RESET_PC default
  - bus field offsets: PC [31:0], INST [63:32], ADEF [64]
  - BR_BUS_WD = 33 for {br_taken, br_target}
- One natural sub-module, fetch_inst_buffer: the 32-bit skid register with buf_valid and its capture/clear/bypass logic.
- The PC/handshake logic stays in inst_fetch_stage.

Test Plan:
- Reset release, ds_allowin = 1 -> addr 0x1c000000 on the first en cycle, then 0x1c000004 and 0x1c000008 on consecutive cycles; the bus pc/inst pairs match SRAM contents one cycle later.
- Stall: ds_allowin = 0 for 3 cycles after pc 0x1c000004 is fetched -> inst_sram_en = 0, bus holds {inst@0x1c000004, 0x1c000004} stable; on release, the next request is 0x1c000008 with no duplicate or lost instruction.
- Redirect: br_taken = 1, br_target = 0x1c000100 while IF holds 0x1c000008 -> fs_to_ds_valid = 0 that cycle, addr = 0x1c000100, next delivered pc = 0x1c000100.
- Redirect during stall with the buffer full -> buffer dropped, buf_valid = 0, fetch resumes at the target.
- Reset asserted mid-stream for 2 cycles -> fs_to_ds_valid and inst_sram_en drop asynchronously; after release, fetch restarts at 0x1c000000.
- With FS_ADEF_CHECK_EN: br_target = 0x1c000102 -> inst_sram_en = 0, delivered bus has adef = 1, pc = 0x1c000102, inst = 0.
